// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped, write-through, no-write-allocate L1 data cache
//            controller for the Memory stage. One 32-bit word per line.
//            Loads that hit return data in the same cycle; misses refill
//            through the single-port backing memory (IDLE -> FILL -> DONE).
//            Optional macro DCACHE_STATS_EN adds saturating HitCount and
//            MissCount outputs.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int IDX_BITS = 6,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Invalidate,
  output logic [31:0]       RD,
  output logic              Cache_ReadReady,
  output logic              Mem_Req,
  output logic              RW,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WD,
  input  logic [31:0]       Mem_RD,
  input  logic              Mem_ReadReady
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       HitCount,
  output logic [15:0]       MissCount
`endif
);

  localparam int c_LINES = 1 << IDX_BITS;
  localparam int c_TAG_W = ADDR_W - IDX_BITS - 2;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FILL = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [c_LINES-1:0] r_valid;
  logic [c_TAG_W-1:0] r_tag  [c_LINES];
  logic [31:0]        r_data [c_LINES];
  logic [31:0]        r_refill;
  logic               r_invSeen;

  logic [IDX_BITS-1:0] w_idx;
  logic [c_TAG_W-1:0]  w_addrTag;
  logic                w_hit;
  logic                w_store;
  logic                w_loadHit;
  logic                w_loadMiss;
  logic                w_fill;

  assign w_idx     = Addr[IDX_BITS+1:2];
  assign w_addrTag = Addr[ADDR_W-1:IDX_BITS+2];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_addrTag);

  // A store takes priority over a simultaneous (illegal) load request.
  assign w_store    = (r_state == c_IDLE) && MemWrite;
  assign w_loadHit  = (r_state == c_IDLE) && MemRead && !MemWrite && w_hit;
  assign w_loadMiss = (r_state == c_IDLE) && MemRead && !MemWrite && !w_hit;
  // Memory responses are only meaningful while a refill is outstanding.
  assign w_fill     = (r_state == c_FILL) && Mem_ReadReady;

  assign Mem_Addr = Addr;
  assign Mem_WD   = WD;

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= c_IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic; Addr/MemRead are held by the pipeline during a refill
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (w_loadMiss) w_nextState = c_FILL;
      c_FILL:  if (Mem_ReadReady) w_nextState = c_DONE;
      c_DONE:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Output decode: hit data in IDLE, memory request in FILL, refill data in DONE
  always_comb begin
    RD              = 32'd0;
    Cache_ReadReady = 1'b0;
    Mem_Req         = 1'b0;
    RW              = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_store) begin
          Mem_Req = 1'b1;
          RW      = 1'b1;
        end else if (w_loadHit) begin
          Cache_ReadReady = 1'b1;
          RD              = r_data[w_idx];
        end
      end
      c_FILL: begin
        Mem_Req = 1'b1;
        RW      = 1'b0;
      end
      c_DONE: begin
        Cache_ReadReady = 1'b1;
        RD              = r_refill;
      end
      default: ;
    endcase
  end

  // Valid bits: invalidate beats a concurrent fill, and an invalidate seen
  // earlier in the same refill keeps the refilled line invalid
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                      r_valid <= '0;
    else if (Invalidate)              r_valid <= '0;
    else if (w_fill && !r_invSeen)    r_valid[w_idx] <= 1'b1;
  end

  // Remembers an invalidate that arrived while the refill was in flight
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                                r_invSeen <= 1'b0;
    else if (w_loadMiss)                        r_invSeen <= 1'b0;
    else if ((r_state == c_FILL) && Invalidate) r_invSeen <= 1'b1;
  end

  // Tag/data arrays: refill overwrites (evicts) the line; store hits update data
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_data[w_idx] <= Mem_RD;
      r_tag[w_idx]  <= w_addrTag;
    end else if (w_store && w_hit) begin
      r_data[w_idx] <= WD;
    end
  end

  // Refill buffer presents the returned word during DONE
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)     r_refill <= 32'd0;
    else if (w_fill) r_refill <= Mem_RD;
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hitCount;
  logic [15:0] r_missCount;

  // Saturating hit/miss counters; stores are not counted
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_hitCount  <= 16'd0;
      r_missCount <= 16'd0;
    end else begin
      if (w_loadHit && (r_hitCount != 16'hFFFF))   r_hitCount  <= r_hitCount + 16'd1;
      if (w_loadMiss && (r_missCount != 16'hFFFF)) r_missCount <= r_missCount + 16'd1;
    end
  end

  assign HitCount  = r_hitCount;
  assign MissCount = r_missCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Self-checking bench for dcache_ctrl. Directed scenarios with
//            literal expectations, then randomized loads/stores/invalidates
//            against a transaction-level cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [31:0] Addr, WD, RD, Mem_Addr, Mem_WD, Mem_RD;
  logic        MemRead, MemWrite, Invalidate, Cache_ReadReady;
  logic        Mem_Req, RW, Mem_ReadReady;
`ifdef DCACHE_STATS_EN
  logic [15:0] HitCount, MissCount;
`endif

  dcache_ctrl #(.IDX_BITS(6), .ADDR_W(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Addr(Addr), .WD(WD),
    .MemRead(MemRead), .MemWrite(MemWrite), .Invalidate(Invalidate),
    .RD(RD), .Cache_ReadReady(Cache_ReadReady), .Mem_Req(Mem_Req), .RW(RW),
    .Mem_Addr(Mem_Addr), .Mem_WD(Mem_WD), .Mem_RD(Mem_RD),
    .Mem_ReadReady(Mem_ReadReady)
`ifdef DCACHE_STATS_EN
    , .HitCount(HitCount), .MissCount(MissCount)
`endif
  );

  always #5 CLK = ~CLK;

  // Cache model: contents per index plus statistics
  bit          mValid [64];
  logic [23:0] mTag   [64];
  logic [31:0] mData  [64];
  int          mHits, mMisses;

  // Expected outputs for the current cycle
  bit          chkEn;
  logic        expRR, expReq, expRW;
  logic [31:0] expRD;

  int checks = 0;
  int errors = 0;
  int cycNum = 0;
  int obsRdyCyc, loadStart;
  logic [31:0] obsRD;

  always @(posedge CLK) cycNum <= cycNum + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model's expectations
  always @(negedge CLK) begin
    if (chkEn) begin
      check("Cache_ReadReady", {31'd0, Cache_ReadReady}, {31'd0, expRR});
      if (expRR) check("RD", RD, expRD);
      check("Mem_Req", {31'd0, Mem_Req}, {31'd0, expReq});
      if (expReq) check("RW", {31'd0, RW}, {31'd0, expRW});
      check("Mem_Addr", Mem_Addr, Addr);
      check("Mem_WD", Mem_WD, WD);
`ifdef DCACHE_STATS_EN
      check("HitCount", {16'd0, HitCount}, mHits);
      check("MissCount", {16'd0, MissCount}, mMisses);
`endif
      if (Cache_ReadReady) begin
        obsRdyCyc = cycNum;
        obsRD     = RD;
      end
    end
  end

  function automatic bit mHit(input logic [31:0] a);
    return mValid[a[7:2]] && (mTag[a[7:2]] == a[31:8]);
  endfunction

  task automatic clearValid();
    foreach (mValid[i]) mValid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setIdle();
    MemRead = 0; MemWrite = 0; Invalidate = 0; Mem_ReadReady = 0;
    Mem_RD = $urandom; Addr = $urandom; WD = $urandom;
    expRR = 0; expReq = 0; expRW = 0; expRD = 32'd0;
  endtask

  task automatic doIdle(input bit spurious, input bit inv);
    setIdle();
    Mem_ReadReady = spurious;
    Invalidate    = inv;
    tick();
    if (inv) clearValid();
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input bit alsoRead, input bit inv);
    bit hit;
    hit = mHit(a);
    setIdle();
    Addr = a; WD = d; MemWrite = 1; MemRead = alsoRead; Invalidate = inv;
    expReq = 1; expRW = 1;
    tick();
    if (hit) mData[a[7:2]] = d;
    if (inv) clearValid();
  endtask

  task automatic doLoad(input logic [31:0] a, input int lat, input int invAt,
                        input bit invIdle, input logic [31:0] fillData);
    int  idx;
    bit  invSeen;
    idx = int'(a[7:2]);
    setIdle();
    Addr = a; MemRead = 1; Invalidate = invIdle;
    loadStart = cycNum;
    obsRdyCyc = -1;
    if (mHit(a)) begin
      expRR = 1; expRD = mData[idx];
      tick();
      if (mHits < 16'hFFFF) mHits++;
      if (invIdle) clearValid();
      return;
    end
    tick();
    if (mMisses < 16'hFFFF) mMisses++;
    if (invIdle) clearValid();
    invSeen = 0;
    for (int k = 1; k <= lat; k++) begin
      Mem_ReadReady = (k == lat);
      Mem_RD        = (k == lat) ? fillData : $urandom;
      Invalidate    = (k == invAt);
      expRR = 0; expReq = 1; expRW = 0;
      tick();
      if (k == invAt) begin
        clearValid();
        invSeen = 1;
      end
      if (k == lat) begin
        mData[idx] = fillData;
        mTag[idx]  = a[31:8];
        if (!invSeen) mValid[idx] = 1'b1;
      end
    end
    // DONE: a stray memory response here must be ignored
    Mem_ReadReady = 1'($urandom_range(0, 1));
    Mem_RD        = $urandom;
    Invalidate    = 0;
    expReq = 0; expRR = 1; expRD = fillData;
    tick();
  endtask

  task automatic checkLoad(input string name, input int expLat, input logic [31:0] expData);
    check({name, " latency"}, obsRdyCyc - loadStart + 1, expLat);
    check({name, " data"}, obsRD, expData);
  endtask

  logic [31:0] ra, rfill;
  int          rlat, rinv;

  initial begin
    RESETn = 0;
    chkEn  = 0;
    mHits = 0; mMisses = 0;
    clearValid();
    setIdle();
    #12;
    check("reset RD", RD, 32'd0);
    check("reset ReadReady", {31'd0, Cache_ReadReady}, 32'd0);
    check("reset Mem_Req", {31'd0, Mem_Req}, 32'd0);
    check("reset RW", {31'd0, RW}, 32'd0);
`ifdef DCACHE_STATS_EN
    check("reset HitCount", {16'd0, HitCount}, 32'd0);
    check("reset MissCount", {16'd0, MissCount}, 32'd0);
`endif
    @(posedge CLK);
    #1;
    RESETn = 1;
    chkEn  = 1;

    // Cold miss, then hit, then store hit and reload
    doLoad(32'h100, 3, 0, 0, 32'h1234_5678);
    checkLoad("cold load", 5, 32'h1234_5678);
    doLoad(32'h100, 3, 0, 0, 32'h0);
    checkLoad("repeat load", 1, 32'h1234_5678);
    doStore(32'h100, 32'hDEAD_BEEF, 0, 0);
    doLoad(32'h100, 3, 0, 0, 32'h0);
    checkLoad("load after store", 1, 32'hDEAD_BEEF);

    // Aliasing on index 0: 0x200 evicts 0x100
    doLoad(32'h200, 2, 0, 0, 32'hA5A5_A5A5);
    checkLoad("alias load", 4, 32'hA5A5_A5A5);
    doLoad(32'h100, 3, 0, 0, 32'h1111_2222);
    checkLoad("evicted reload", 5, 32'h1111_2222);

    // Invalidate mid-fill: data returned, line stays invalid
    doLoad(32'h300, 4, 2, 0, 32'h0BAD_F00D);
    checkLoad("inv during fill", 6, 32'h0BAD_F00D);
    doLoad(32'h300, 1, 0, 0, 32'h3333_4444);
    checkLoad("reload after inv", 3, 32'h3333_4444);

    // Invalidate alongside a hit: hit still reported, next access misses
    doLoad(32'h300, 1, 0, 1, 32'h0);
    checkLoad("hit with inv", 1, 32'h3333_4444);
    doLoad(32'h300, 2, 0, 0, 32'h5555_6666);
    checkLoad("miss after inv", 4, 32'h5555_6666);

    // Invalidate on the same edge as the fill write
    doLoad(32'h104, 2, 2, 0, 32'h7777_8888);
    checkLoad("inv at fill", 4, 32'h7777_8888);
    doLoad(32'h104, 1, 0, 0, 32'h9999_AAAA);
    checkLoad("miss after fill-inv", 3, 32'h9999_AAAA);

    // Illegal read+write: store wins, then the stored word hits
    doStore(32'h104, 32'hCAFE_F00D, 1, 0);
    doLoad(32'h104, 1, 0, 0, 32'h0);
    checkLoad("load after rw store", 1, 32'hCAFE_F00D);

    // Randomized traffic over a small aliasing address pool
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (op <= 4) begin
        rlat  = int'($urandom_range(1, 4));
        rinv  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, rlat)) : 0;
        rfill = $urandom;
        doLoad(ra, rlat, rinv, ($urandom_range(0, 9) == 0), rfill);
      end else if (op <= 7) begin
        doStore(ra, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      end else begin
        doIdle(1'($urandom_range(0, 1)), (op == 9));
      end
    end

    // Reset in the middle of a refill
    doIdle(0, 1);
    setIdle();
    Addr = 32'h100; MemRead = 1;
    tick();
    Mem_ReadReady = 0;
    expReq = 1; expRW = 0;
    #2;
    chkEn  = 0;
    RESETn = 0;
    #1;
    check("Mem_Req async reset", {31'd0, Mem_Req}, 32'd0);
    check("ReadReady async reset", {31'd0, Cache_ReadReady}, 32'd0);
`ifdef DCACHE_STATS_EN
    check("HitCount after reset", {16'd0, HitCount}, 32'd0);
    check("MissCount after reset", {16'd0, MissCount}, 32'd0);
`endif
    clearValid();
    mHits = 0; mMisses = 0;
    @(posedge CLK);
    #1;
    RESETn = 1;
    setIdle();
    chkEn = 1;
    doLoad(32'h100, 2, 0, 0, 32'h4242_4242);
    checkLoad("load after reset", 4, 32'h4242_4242);
    doIdle(0, 0);
    chkEn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
